// File: rtl/morse_pkg.sv
// morse_pkg: shared FSM states, symbol codes and timing multipliers for the Morse front end.
package morse_pkg;
  typedef enum logic [1:0] {IDLE, MARK, GAP, LETTER} state_t;
  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_CHAR_END = 2'b11;
  localparam int DASH_MULT = 2;
  localparam int CHAR_MULT = 2;
  localparam int WORD_MULT = 5;
  localparam int MAX_SYMS_DEF = 6;
endpackage

// File: rtl/morse_key_debounce.sv
// morse_key_debounce: two-flop synchroniser followed by a stable-sample debounce counter.
module morse_key_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_db
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      key_db <= 1'b0;
    end else begin
      s1 <= key_in;
      s2 <= s1;
      if (s2 == key_db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE - 1)) begin
        key_db <= s2;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/morse_key_sequencer.sv
// morse_key_sequencer: times debounced key marks/spaces and emits dot/dash/char-end/word strobes.
module morse_key_sequencer
  import morse_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int MAX_SYMS = MAX_SYMS_DEF,
  parameter int DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_in,
  input  logic [CNT_W-1:0]    unit_len,
  output logic [1:0]          morse_signal,
  output logic                sym_valid,
  output logic                char_valid,
  output logic [MAX_SYMS-1:0] seq,
  output logic [2:0]          seq_len,
  output logic                word_space,
  output logic                overflow,
  output logic                busy
);
  localparam int TW = CNT_W + 3;
  state_t state, state_n;
  logic key_db, key_q, rise, dash;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc, unit_r, unit_n;
  logic [TW-1:0] t_dash, t_char, t_word;
  logic [MAX_SYMS-1:0] seq_n;
  logic [2:0] len_n;
  logic [1:0] sig_n;
  logic ovf_n, sv_n, cv_n, ws_n;

  morse_key_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .key_db(key_db)
  );

  assign rise = key_db & ~key_q;
  assign cnt_inc = &cnt ? cnt : cnt + CNT_W'(1);
  assign t_dash = TW'(unit_r) * TW'(DASH_MULT);
  assign t_char = TW'(unit_r) * TW'(CHAR_MULT);
  assign t_word = TW'(unit_r) * TW'(WORD_MULT);
  // a saturated counter must still read as a dash even if T_DASH exceeds its range
  assign dash = (&cnt) | (TW'(cnt) >= t_dash);
  assign busy = state != IDLE;

  always_comb begin
    state_n = state;
    cnt_n = cnt_inc;
    unit_n = unit_r;
    seq_n = seq;
    len_n = seq_len;
    ovf_n = overflow;
    sig_n = SYM_NONE;
    sv_n = 1'b0;
    cv_n = 1'b0;
    ws_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = cnt;
        if (rise) begin
          state_n = MARK;
          cnt_n = CNT_W'(1);
          unit_n = unit_len == '0 ? CNT_W'(1) : unit_len;
          seq_n = '0;
          len_n = '0;
          ovf_n = 1'b0;
        end
      end
      MARK: if (!key_db) begin
        state_n = GAP;
        cnt_n = CNT_W'(1);
        sv_n = 1'b1;
        sig_n = dash ? SYM_DASH : SYM_DOT;
        if (seq_len < 3'(MAX_SYMS)) begin
          seq_n = MAX_SYMS'({seq, dash});
          len_n = seq_len + 3'd1;
        end else ovf_n = 1'b1;
      end
      GAP: if (rise) begin
        state_n = MARK;
        cnt_n = CNT_W'(1);
      end else if (TW'(cnt_inc) >= t_char) begin
        state_n = LETTER;
        cv_n = 1'b1;
        sig_n = SYM_CHAR_END;
      end
      LETTER: if (rise) begin
        state_n = MARK;
        cnt_n = CNT_W'(1);
        seq_n = '0;
        len_n = '0;
        ovf_n = 1'b0;
      end else if (TW'(cnt_inc) >= t_word) begin
        state_n = IDLE;
        cnt_n = '0;
        ws_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      unit_r <= '0;
      key_q <= 1'b0;
      seq <= '0;
      seq_len <= '0;
      overflow <= 1'b0;
      morse_signal <= SYM_NONE;
      sym_valid <= 1'b0;
      char_valid <= 1'b0;
      word_space <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      unit_r <= unit_n;
      key_q <= key_db;
      seq <= seq_n;
      seq_len <= len_n;
      overflow <= ovf_n;
      morse_signal <= sig_n;
      sym_valid <= sv_n;
      char_valid <= cv_n;
      word_space <= ws_n;
    end
  end
endmodule
